// File: rtl/push_button_conditioner_pkg.sv
// Shared constants and types for the push-button input path:
// button indices, default timing at 100 MHz, and the repeat-FSM encoding.
package push_button_conditioner_pkg;

  localparam int unsigned N_BTN = 5;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_M = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_RATE     = 15000000;  // 0.15 s
  localparam logic [N_BTN-1:0] DEF_REPEAT_MASK = 5'b00011;

  typedef enum logic [1:0] {
    RPT_IDLE       = 2'd0,
    RPT_WAIT_FIRST = 2'd1,
    RPT_REPEATING  = 2'd2
  } rpt_state_t;

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/push_button_conditioner_if.sv
// Button bundle between the pins side (master) and the conditioner (slave).
interface push_button_conditioner_if;
  import push_button_conditioner_pkg::*;

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_pulse;
  logic             any_press;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_pulse, any_press
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_pulse, any_press
  );

endinterface

// File: rtl/push_button_conditioner_button_channel.sv
// One button: 2-FF synchronizer, restart-on-match debounce, registered
// press/release edges and an optional auto-repeat FSM.
module button_channel
  import push_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk_osc,
  input  logic resetn,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_pulse,
  output logic press_c
);

  localparam int unsigned CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RCNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCNT_W   = cnt_width(RCNT_MAX);
  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RR_LAST = RCNT_W'(REPEAT_RATE - 1);

  logic              sync1, sync2;
  logic [CNT_W-1:0]  db_cnt, db_cnt_next;
  logic              level_upd_c, rise_c, fall_c, rpt_c;
  rpt_state_t        state, state_next;
  logic [RCNT_W-1:0] rcnt, rcnt_next;

  // Debounce: any sample equal to the stable level restarts the count.
  always_comb begin
    db_cnt_next = '0;
    level_upd_c = 1'b0;
    if (sync2 != btn_level) begin
      if (db_cnt == DB_LAST) begin
        level_upd_c = 1'b1;
      end else begin
        db_cnt_next = db_cnt + CNT_W'(1);
      end
    end
  end

  assign rise_c  = level_upd_c & sync2;
  assign fall_c  = level_upd_c & ~sync2;
  assign press_c = rise_c;

  // Repeat FSM next-state; a release wins over a repeat due in the same cycle.
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    rpt_c      = 1'b0;
    case (state)
      RPT_IDLE: begin
        if (rise_c && REPEAT_EN) begin
          state_next = RPT_WAIT_FIRST;
          rcnt_next  = '0;
        end
      end
      RPT_WAIT_FIRST: begin
        if (rcnt == RD_LAST) begin
          rpt_c      = 1'b1;
          rcnt_next  = '0;
          state_next = RPT_REPEATING;
        end else begin
          rcnt_next = rcnt + RCNT_W'(1);
        end
      end
      RPT_REPEATING: begin
        if (rcnt == RR_LAST) begin
          rpt_c     = 1'b1;
          rcnt_next = '0;
        end else begin
          rcnt_next = rcnt + RCNT_W'(1);
        end
      end
      default: begin
        state_next = RPT_IDLE;
        rcnt_next  = '0;
      end
    endcase
    if (fall_c) begin
      state_next = RPT_IDLE;
      rcnt_next  = '0;
      rpt_c      = 1'b0;
    end
  end

  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_pulse   <= 1'b0;
      state       <= RPT_IDLE;
      rcnt        <= '0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      db_cnt      <= db_cnt_next;
      if (level_upd_c) begin
        btn_level <= sync2;
      end
      btn_press   <= rise_c;
      btn_release <= fall_c;
      btn_pulse   <= rise_c | rpt_c;
      state       <= state_next;
      rcnt        <= rcnt_next;
    end
  end

endmodule

// File: rtl/push_button_conditioner.sv
// Conditions the five raw push buttons into clean level/press/release/pulse
// signals; channels are fully independent.
module push_button_conditioner
  import push_button_conditioner_pkg::*;
#(
  parameter int unsigned      DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned      REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned      REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
  input logic                      clk_osc,
  input logic                      resetn,
  push_button_conditioner_if.slave bus
);

  logic [N_BTN-1:0] level_w, press_w, release_w, pulse_w, press_c;
  logic             any_press_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_channel (
      .clk_osc     (clk_osc),
      .resetn      (resetn),
      .btn_raw     (bus.btn_raw[i]),
      .btn_level   (level_w[i]),
      .btn_press   (press_w[i]),
      .btn_release (release_w[i]),
      .btn_pulse   (pulse_w[i]),
      .press_c     (press_c[i])
    );
  end

  // Registered from the same next-cycle presses so it coincides with btn_press.
  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_c;
    end
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_pulse   = pulse_w;
  assign bus.any_press   = any_press_q;

endmodule
